matrix_mult_vector_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `matrix_mult_vector` instance among `NUM_REQ` requesters. It captures the winning requester's operands and drives the multiplier's `i_calc`/`i_rst_n`. It waits for `o_ready`, then returns the result to that requester with a one-cycle done strobe. A watchdog resets a hung multiplier and reports an error, so the pipeline cannot deadlock.

---
 rtl/matrix_mult_vector_arbiter_if.sv | 38 +++
 rtl/matrix_mult_vector_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_matrix_mult_vector_arbiter.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_mult_vector_arbiter_if.sv
// Bundle of requester-side and multiplier-side signals of the shared matrix-vector arbiter.
// Handshake: a requester holds i_req and its operands until it sees its o_gnt pulse (operands captured); o_done pulses once per job with o_result/o_err valid.
interface matrix_mult_vector_arbiter_if #(
  parameter int MATRIX_WIDTH  = 2,
  parameter int MATRIX_HEIGHT = 2,
  parameter int DATA_WIDTH    = 8,
  parameter int NUM_REQ       = 2
);
  localparam int MS = MATRIX_WIDTH * MATRIX_HEIGHT * DATA_WIDTH;
  localparam int VS = MATRIX_WIDTH * DATA_WIDTH;

  logic [NUM_REQ-1:0]    i_req;
  logic [NUM_REQ*MS-1:0] i_matrix;
  logic [NUM_REQ*VS-1:0] i_vector;
  logic [NUM_REQ-1:0]    o_gnt;
  logic [NUM_REQ-1:0]    o_done;
  logic [MS-1:0]         o_result;
  logic                  o_err;
  logic                  o_busy;
  logic                  o_mul_calc;
  logic                  o_mul_rst_n;
  logic [MS-1:0]         o_mul_matrix;
  logic [VS-1:0]         o_mul_vector;
  logic [MS-1:0]         i_mul_result;
  logic                  i_mul_ready;

  modport slave (
    input  i_req, i_matrix, i_vector, i_mul_result, i_mul_ready,
    output o_gnt, o_done, o_result, o_err, o_busy,
           o_mul_calc, o_mul_rst_n, o_mul_matrix, o_mul_vector
  );

  modport master (
    output i_req, i_matrix, i_vector, i_mul_result, i_mul_ready,
    input  o_gnt, o_done, o_result, o_err, o_busy,
           o_mul_calc, o_mul_rst_n, o_mul_matrix, o_mul_vector
  );
endinterface

// File: rtl/matrix_mult_vector_arbiter.sv
// Round-robin arbiter/sequencer sharing one matrix_mult_vector among NUM_REQ requesters,
// with a watchdog that resets a hung multiplier and completes the job with an error.
module matrix_mult_vector_arbiter #(
  parameter int MATRIX_WIDTH   = 2,
  parameter int MATRIX_HEIGHT  = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int MATRIX_WEIGHT  = MATRIX_WIDTH * MATRIX_HEIGHT,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          i_rst,
  matrix_mult_vector_arbiter_if.slave   bus,
  output logic [2:0]                    o_dbg_state
);
  localparam int MS    = MATRIX_WEIGHT * DATA_WIDTH;
  localparam int VS    = MATRIX_WIDTH * DATA_WIDTH;
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CALC    = 3'd1,
    S_WAIT    = 3'd2,
    S_RECOVER = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr_nxt;
  logic [IDX_W-1:0]   r_winner, w_winner_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_nxt;
  logic [NUM_REQ-1:0] r_done, w_done_nxt;
  logic [MS-1:0]      r_result, w_result_nxt;
  logic               r_err, w_err_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_calc, w_calc_nxt;
  logic               r_mul_rst_n, w_mul_rst_n_nxt;
  logic [MS-1:0]      r_mul_matrix, w_mul_matrix_nxt;
  logic [VS-1:0]      r_mul_vector, w_mul_vector_nxt;

  logic               w_rr_found;
  logic [IDX_W-1:0]   w_rr_idx;
  int                 w_best_dist;
  logic [MS-1:0]      w_sel_matrix;
  logic [VS-1:0]      w_sel_vector;

  // Winner is the requester at the smallest circular distance from r_ptr.
  always_comb begin
    w_rr_found  = 1'b0;
    w_rr_idx    = '0;
    w_best_dist = NUM_REQ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (bus.i_req[i] && (((i - int'(r_ptr) + NUM_REQ) % NUM_REQ) < w_best_dist)) begin
        w_rr_found  = 1'b1;
        w_rr_idx    = IDX_W'(i);
        w_best_dist = (i - int'(r_ptr) + NUM_REQ) % NUM_REQ;
      end
    end
  end

  always_comb begin
    w_sel_matrix = '0;
    w_sel_vector = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (i == int'(w_rr_idx)) begin
        w_sel_matrix = bus.i_matrix[i*MS +: MS];
        w_sel_vector = bus.i_vector[i*VS +: VS];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_ptr_nxt        = r_ptr;
    w_winner_nxt     = r_winner;
    w_cnt_nxt        = r_cnt;
    w_gnt_nxt        = '0;
    w_done_nxt       = '0;
    w_result_nxt     = r_result;
    w_err_nxt        = r_err;
    w_mul_matrix_nxt = r_mul_matrix;
    w_mul_vector_nxt = r_mul_vector;
    case (r_state)
      S_IDLE: begin
        if (w_rr_found) begin
          w_state_nxt      = S_CALC;
          w_winner_nxt     = w_rr_idx;
          w_ptr_nxt        = IDX_W'((int'(w_rr_idx) + 1) % NUM_REQ);
          w_mul_matrix_nxt = w_sel_matrix;
          w_mul_vector_nxt = w_sel_vector;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(w_rr_idx)) w_gnt_nxt[i] = 1'b1;
          end
        end
      end
      // Ready is deliberately not looked at here: it may be left over from the previous job.
      S_CALC: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.i_mul_ready) begin
          w_result_nxt = bus.i_mul_result;
          w_err_nxt    = 1'b0;
          w_state_nxt  = S_DONE;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (i == int'(r_winner)) w_done_nxt[i] = 1'b1;
          end
        end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt = S_RECOVER;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        w_result_nxt = '0;
        w_err_nxt    = 1'b1;
        w_state_nxt  = S_DONE;
        for (int i = 0; i < NUM_REQ; i++) begin
          if (i == int'(r_winner)) w_done_nxt[i] = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // State-decoded outputs are registered from the next state so they align with it.
    w_calc_nxt      = (w_state_nxt == S_CALC) || (w_state_nxt == S_WAIT);
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    w_mul_rst_n_nxt = (w_state_nxt != S_RECOVER);
  end

  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_ptr        <= '0;
      r_winner     <= '0;
      r_cnt        <= '0;
      r_gnt        <= '0;
      r_done       <= '0;
      r_result     <= '0;
      r_err        <= 1'b0;
      r_busy       <= 1'b0;
      r_calc       <= 1'b0;
      r_mul_rst_n  <= 1'b0;
      r_mul_matrix <= '0;
      r_mul_vector <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_winner     <= w_winner_nxt;
      r_cnt        <= w_cnt_nxt;
      r_gnt        <= w_gnt_nxt;
      r_done       <= w_done_nxt;
      r_result     <= w_result_nxt;
      r_err        <= w_err_nxt;
      r_busy       <= w_busy_nxt;
      r_calc       <= w_calc_nxt;
      r_mul_rst_n  <= w_mul_rst_n_nxt;
      r_mul_matrix <= w_mul_matrix_nxt;
      r_mul_vector <= w_mul_vector_nxt;
    end
  end

  assign bus.o_gnt        = r_gnt;
  assign bus.o_done       = r_done;
  assign bus.o_result     = r_result;
  assign bus.o_err        = r_err;
  assign bus.o_busy       = r_busy;
  assign bus.o_mul_calc   = r_calc;
  assign bus.o_mul_rst_n  = r_mul_rst_n;
  assign bus.o_mul_matrix = r_mul_matrix;
  assign bus.o_mul_vector = r_mul_vector;
  assign o_dbg_state      = r_state;
endmodule

// File: tb/tb_matrix_mult_vector_arbiter.sv
// Bench for matrix_mult_vector_arbiter: behavioural multiplier stand-in, per-feature tasks,
// expected-completion queue popped on each o_done.
module tb_matrix_mult_vector_arbiter;
  localparam int MS = 32;
  localparam int VS = 16;
  localparam int TO = 4;
  localparam int EW = 2 + 1 + MS;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  int gnt_seen  = 0;

  logic [EW-1:0] exp_q[$];

  // Multiplier stand-in controls.
  int          mdl_delay    = 2;
  bit          mdl_stuck    = 0;
  bit          mdl_hang     = 0;
  bit          mdl_fixed_en = 0;
  logic [31:0] mdl_fixed    = '0;
  int          calc_cnt     = 0;

  matrix_mult_vector_arbiter_if #(
    .MATRIX_WIDTH(2), .MATRIX_HEIGHT(2), .DATA_WIDTH(8), .NUM_REQ(2)
  ) bus ();

  matrix_mult_vector_arbiter #(
    .MATRIX_WIDTH(2), .MATRIX_HEIGHT(2), .DATA_WIDTH(8),
    .NUM_REQ(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .i_rst(rst),
    .bus(bus),
    .o_dbg_state(dbg_state)
  );

  function automatic logic [31:0] mul_fn(input logic [31:0] m, input logic [15:0] v);
    return m ^ {v, v} ^ 32'h5A5A_5A5A;
  endfunction

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Multiplier stand-in: ready after mdl_delay full WAIT cycles (CALC counts as the first calc cycle).
  initial begin
    bus.i_mul_ready  = 1'b0;
    bus.i_mul_result = '0;
    forever begin
      @(negedge clk);
      if (bus.o_mul_calc && bus.o_mul_rst_n) calc_cnt++;
      else calc_cnt = 0;
      bus.i_mul_result = mdl_fixed_en ? mdl_fixed : mul_fn(bus.o_mul_matrix, bus.o_mul_vector);
      if (mdl_stuck)     bus.i_mul_ready = 1'b1;
      else if (mdl_hang) bus.i_mul_ready = 1'b0;
      else               bus.i_mul_ready = (calc_cnt >= mdl_delay + 2);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (bus.o_done != 2'b00) done_seen++;
      if (bus.o_gnt != 2'b00)  gnt_seen++;
    end
  end

  // driver tasks
  task automatic wait_gnt(input int budget, output logic [1:0] g, output int cyc);
    g = 2'b00;
    cyc = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (bus.o_gnt != 2'b00) begin
        g = bus.o_gnt;
        return;
      end
    end
  endtask

  task automatic wait_done(input int budget, output logic [1:0] d, output logic e,
                           output logic [31:0] r, output int cyc, output int rstn_low);
    d = 2'b00; e = 1'b0; r = '0; cyc = 0; rstn_low = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cyc++;
      if (!bus.o_mul_rst_n) rstn_low++;
      if (bus.o_done != 2'b00) begin
        d = bus.o_done;
        e = bus.o_err;
        r = bus.o_result;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.i_req = '0; bus.i_matrix = '0; bus.i_vector = '0;
    @(negedge clk);
    n_checks++;
    if ({bus.o_gnt, bus.o_done, bus.o_err, bus.o_busy, bus.o_mul_calc, bus.o_result} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b done=%b err=%b busy=%b calc=%b result=%h, expected all zero",
               bus.o_gnt, bus.o_done, bus.o_err, bus.o_busy, bus.o_mul_calc, bus.o_result);
    end
    n_checks++;
    if ({bus.o_mul_matrix, bus.o_mul_vector} !== '0) begin
      n_fail++;
      $display("FAIL reset_operands: got %h/%h expected 0/0", bus.o_mul_matrix, bus.o_mul_vector);
    end
    n_checks++;
    if (bus.o_mul_rst_n !== 1'b0 || dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_mul_rst_n: got rst_n=%b state=%0d expected 0/0", bus.o_mul_rst_n, dbg_state);
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus.o_mul_rst_n !== 1'b1 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got rst_n=%b busy=%b expected 1/0", bus.o_mul_rst_n, bus.o_busy);
    end
  endtask

  task automatic test_contention();
    logic [31:0] m0, m1, r;
    logic [15:0] v0, v1;
    logic [1:0]  g, d, exp_gnt[3];
    logic        e;
    logic [EW-1:0] x;
    int c1, c2, rl;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
    m0 = $urandom; m1 = $urandom; v0 = 16'($urandom); v1 = 16'($urandom);
    mdl_delay = $urandom_range(0, 2);
    @(negedge clk);
    bus.i_matrix = {m1, m0};
    bus.i_vector = {v1, v0};
    bus.i_req    = 2'b11;
    exp_q.push_back({2'b01, 1'b0, mul_fn(m0, v0)});
    exp_q.push_back({2'b10, 1'b0, mul_fn(m1, v1)});
    exp_q.push_back({2'b01, 1'b0, mul_fn(m0, v0)});
    for (int j = 0; j < 3; j++) begin
      wait_gnt(20, g, c1);
      if (j == 2) bus.i_req = 2'b00;
      n_checks++;
      if (g !== exp_gnt[j]) begin
        n_fail++;
        $display("FAIL contention_gnt%0d: got %b expected %b", j, g, exp_gnt[j]);
      end
      wait_done(20, d, e, r, c2, rl);
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL contention_done%0d: got done=%b with no expected job queued", j, d);
      end else begin
        x = exp_q.pop_front();
        if ({d, e, r} !== x) begin
          n_fail++;
          $display("FAIL contention_done%0d: got {done,err,result}=%h expected %h", j, {d, e, r}, x);
        end
      end
    end
  endtask

  task automatic test_single_job();
    logic [1:0] g, d;
    logic e;
    logic [31:0] r;
    logic [EW-1:0] x;
    int c1, c2, rl;
    mdl_fixed_en = 1; mdl_fixed = 32'h0000_3EF8; mdl_delay = 2;
    @(negedge clk);
    bus.i_matrix[31:0] = {8'd2, 8'd3, 8'd6, 8'd14};
    bus.i_vector[15:0] = {8'd10, 8'd14};
    bus.i_req = 2'b01;
    exp_q.push_back({2'b01, 1'b0, 32'h0000_3EF8});
    wait_gnt(20, g, c1);
    bus.i_req = 2'b00;
    n_checks++;
    if (g !== 2'b01 || c1 != 1) begin
      n_fail++;
      $display("FAIL single_gnt: got %b after %0d cycles expected 01 after 1", g, c1);
    end
    n_checks++;
    if (bus.o_mul_matrix !== 32'h0203060E || bus.o_mul_vector !== 16'h0A0E) begin
      n_fail++;
      $display("FAIL single_operands: got %h/%h expected 0203060e/0a0e", bus.o_mul_matrix, bus.o_mul_vector);
    end
    n_checks++;
    if (bus.o_busy !== 1'b1 || bus.o_mul_calc !== 1'b1) begin
      n_fail++;
      $display("FAIL single_calc: got busy=%b calc=%b expected 1/1", bus.o_busy, bus.o_mul_calc);
    end
    wait_done(20, d, e, r, c2, rl);
    n_checks++;
    if (c1 + c2 != 5) begin
      n_fail++;
      $display("FAIL single_latency: got %0d cycles expected 5", c1 + c2);
    end
    n_checks++;
    x = exp_q.pop_front();
    if ({d, e, r} !== x) begin
      n_fail++;
      $display("FAIL single_done: got {done,err,result}=%h expected %h", {d, e, r}, x);
    end
    @(negedge clk);
    n_checks++;
    if (bus.o_result !== 32'h0000_3EF8 || bus.o_done !== 2'b00 || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_hold: got result=%h done=%b busy=%b expected 00003ef8/00/0",
               bus.o_result, bus.o_done, bus.o_busy);
    end
    mdl_fixed_en = 0;
  endtask

  task automatic test_stale_ready();
    logic [1:0] g, d;
    logic e;
    logic [31:0] r, m;
    logic [15:0] v;
    logic [EW-1:0] x;
    int c1, c2, rl;
    m = $urandom; v = 16'($urandom);
    mdl_stuck = 1;
    @(negedge clk);
    @(negedge clk);
    bus.i_matrix[31:0] = m;
    bus.i_vector[15:0] = v;
    bus.i_req = 2'b01;
    exp_q.push_back({2'b01, 1'b0, mul_fn(m, v)});
    wait_gnt(20, g, c1);
    bus.i_req = 2'b00;
    wait_done(20, d, e, r, c2, rl);
    n_checks++;
    if (c1 + c2 != 3) begin
      n_fail++;
      $display("FAIL stale_latency: got %0d cycles expected 3", c1 + c2);
    end
    n_checks++;
    x = exp_q.pop_front();
    if ({d, e, r} !== x) begin
      n_fail++;
      $display("FAIL stale_done: got {done,err,result}=%h expected %h", {d, e, r}, x);
    end
    mdl_stuck = 0;
  endtask

  task automatic test_timeout();
    logic [1:0] g, d;
    logic e;
    logic [31:0] r, m;
    logic [15:0] v;
    logic [EW-1:0] x;
    int c1, c2, rl;
    // hung multiplier
    mdl_hang = 1;
    @(negedge clk);
    bus.i_matrix = {$urandom, $urandom};
    bus.i_req = 2'b10;
    exp_q.push_back({2'b10, 1'b1, 32'h0});
    wait_gnt(20, g, c1);
    bus.i_req = 2'b00;
    wait_done(40, d, e, r, c2, rl);
    n_checks++;
    if (rl != 1) begin
      n_fail++;
      $display("FAIL timeout_rst_n_width: got %0d cycles low expected 1", rl);
    end
    n_checks++;
    if (c1 + c2 != TO + 3) begin
      n_fail++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", c1 + c2, TO + 3);
    end
    n_checks++;
    x = exp_q.pop_front();
    if ({d, e, r} !== x) begin
      n_fail++;
      $display("FAIL timeout_done: got {done,err,result}=%h expected %h", {d, e, r}, x);
    end
    mdl_hang = 0;
    // next job completes normally, and ready on the timeout edge still wins
    for (int k = 0; k < 2; k++) begin
      mdl_delay = (k == 0) ? 1 : TO - 1;
      m = $urandom; v = 16'($urandom);
      @(negedge clk);
      bus.i_matrix = {m, m};
      bus.i_vector = {v, v};
      bus.i_req = (k == 0) ? 2'b01 : 2'b10;
      exp_q.push_back({((k == 0) ? 2'b01 : 2'b10), 1'b0, mul_fn(m, v)});
      wait_gnt(20, g, c1);
      bus.i_req = 2'b00;
      wait_done(40, d, e, r, c2, rl);
      n_checks++;
      if (c1 + c2 != mdl_delay + 3) begin
        n_fail++;
        $display("FAIL after_timeout_latency%0d: got %0d cycles expected %0d", k, c1 + c2, mdl_delay + 3);
      end
      n_checks++;
      x = exp_q.pop_front();
      if ({d, e, r} !== x) begin
        n_fail++;
        $display("FAIL after_timeout_done%0d: got {done,err,result}=%h expected %h", k, {d, e, r}, x);
      end
    end
  endtask

  task automatic test_req_dropped();
    logic [1:0] g, d;
    logic e;
    logic [31:0] r, m;
    logic [15:0] v;
    logic [EW-1:0] x;
    int c1, c2, rl, gs;
    m = $urandom; v = 16'($urandom);
    mdl_delay = 2;
    @(negedge clk);
    gs = gnt_seen;
    bus.i_matrix = {m, ~m};
    bus.i_vector = {v, ~v};
    bus.i_req = 2'b10;
    exp_q.push_back({2'b10, 1'b0, mul_fn(m, v)});
    wait_gnt(20, g, c1);
    bus.i_req = 2'b00;
    @(negedge clk);
    bus.i_req = 2'b01;
    @(negedge clk);
    bus.i_req = 2'b00;
    wait_done(20, d, e, r, c2, rl);
    n_checks++;
    x = exp_q.pop_front();
    if ({d, e, r} !== x) begin
      n_fail++;
      $display("FAIL dropped_done: got {done,err,result}=%h expected %h", {d, e, r}, x);
    end
    repeat (4) @(negedge clk);
    n_checks++;
    if (bus.o_busy !== 1'b0 || gnt_seen - gs != 1) begin
      n_fail++;
      $display("FAIL dropped_no_grant: got busy=%b grants=%0d expected 0/1", bus.o_busy, gnt_seen - gs);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [1:0] g, d;
    logic e;
    logic [31:0] r, m;
    logic [15:0] v;
    logic [EW-1:0] x;
    int c1, c2, rl, ds;
    mdl_hang = 1;
    @(negedge clk);
    ds = done_seen;
    bus.i_matrix = {$urandom, $urandom};
    bus.i_req = 2'b01;
    wait_gnt(20, g, c1);
    bus.i_req = 2'b00;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_gnt, bus.o_done, bus.o_err, bus.o_busy, bus.o_mul_calc, bus.o_mul_rst_n,
         bus.o_result, bus.o_mul_matrix, bus.o_mul_vector, dbg_state} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got gnt=%b done=%b err=%b busy=%b calc=%b rst_n=%b result=%h mm=%h mv=%h st=%0d expected all zero",
               bus.o_gnt, bus.o_done, bus.o_err, bus.o_busy, bus.o_mul_calc, bus.o_mul_rst_n,
               bus.o_result, bus.o_mul_matrix, bus.o_mul_vector, dbg_state);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mdl_hang = 0;
    mdl_delay = 1;
    @(negedge clk);
    n_checks++;
    if (done_seen != ds) begin
      n_fail++;
      $display("FAIL reset_no_done: got %0d done pulses expected 0", done_seen - ds);
    end
    // pointer restarts at 0: with both requesting, requester 0 wins
    for (int k = 0; k < 2; k++) begin
      m = $urandom; v = 16'($urandom);
      bus.i_matrix = {m, m};
      bus.i_vector = {v, v};
      bus.i_req = (k == 0) ? 2'b11 : 2'b10;
      exp_q.push_back({((k == 0) ? 2'b01 : 2'b10), 1'b0, mul_fn(m, v)});
      wait_gnt(20, g, c1);
      bus.i_req = 2'b00;
      n_checks++;
      if (g !== ((k == 0) ? 2'b01 : 2'b10)) begin
        n_fail++;
        $display("FAIL post_reset_gnt%0d: got %b expected %b", k, g, (k == 0) ? 2'b01 : 2'b10);
      end
      wait_done(20, d, e, r, c2, rl);
      n_checks++;
      x = exp_q.pop_front();
      if ({d, e, r} !== x) begin
        n_fail++;
        $display("FAIL post_reset_done%0d: got {done,err,result}=%h expected %h", k, {d, e, r}, x);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_job();
    test_stale_ready();
    test_timeout();
    test_req_dropped();
    test_reset_mid_wait();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_jobs: got %0d unfinished expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
